// File: rtl/pipelined_adder.sv
// Pipelined unsigned adder: WIDTH-bit a + b + cin, one CHUNK-wide slice per stage, valid/ready at both ends.
// Optional macro PIPELINED_ADDER_SAT_EN: the final stage forces sum to all ones when the carry-out is set.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CHUNK = WIDTH / STAGES;

  // Finished sum slices enter at the top and shift down one chunk per stage;
  // pending operand bits shift down so the next slice to add always sits at bit 0.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];
  stage_t inStage;
  logic   advance;

  function automatic stage_t addSlice(input stage_t src);
    stage_t         res;
    logic [CHUNK:0] slice;
    slice     = {1'b0, src.a[CHUNK-1:0]} + {1'b0, src.b[CHUNK-1:0]} + {{CHUNK{1'b0}}, src.carry};
    res.valid = src.valid;
    res.carry = slice[CHUNK];
    res.sum   = (src.sum >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
    res.a     = src.a >> CHUNK;
    res.b     = src.b >> CHUNK;
    return res;
  endfunction

  assign advance  = out_ready | ~stage_q[STAGES-1].valid;
  assign in_ready = advance;
  assign inStage  = '{valid: in_valid, carry: cin, sum: '0, a: a, b: b};

  always_comb begin
    stage_d = stage_q;
    if (advance) begin
      stage_d[0] = addSlice(inStage);
      for (int k = 1; k < STAGES; k++) begin
        stage_d[k] = addSlice(stage_q[k-1]);
      end
`ifdef PIPELINED_ADDER_SAT_EN
      if (stage_d[STAGES-1].carry) begin
        stage_d[STAGES-1].sum = '1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_valid = stage_q[STAGES-1].valid;
  assign sum       = stage_q[STAGES-1].sum;
  assign cout      = stage_q[STAGES-1].carry;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4): directed vector table,
// random streams scored against an arithmetic reference model, stall, reset and bubble sequences.
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
`ifdef PIPELINED_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] wrapSum;
    logic             cout;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int               total = 0;
  int               bad = 0;
  int               cycle = 0;
  bit               sbOn = 1'b0;
  logic [WIDTH:0]   expQ [$];
  logic [WIDTH:0]   expVal;
  int               rxCount = 0;
  int               firstRx = 0;
  int               lastRx = 0;
  vec_t             vecs [10];

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference: plain WIDTH+1 bit addition, optionally clamped when the top bit is set.
  function automatic logic [WIDTH:0] refModel(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic c);
    logic [WIDTH:0] full;
    full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    if (SAT && full[WIDTH]) full[WIDTH-1:0] = '1;
    return full;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: samples mid-cycle, pushes accepted operands, pops on every output transfer.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
    end else if (sbOn) begin
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious out_valid", 32'(out_valid), 32'd0);
        end else begin
          expVal = expQ.pop_front();
          checkOutput("stream sum", 32'(sum), 32'(expVal[WIDTH-1:0]));
          checkOutput("stream cout", 32'(cout), 32'(expVal[WIDTH]));
          if (rxCount == 0) firstRx = cycle;
          lastRx = cycle;
          rxCount++;
        end
      end
      if (in_valid && in_ready) expQ.push_back(refModel(a, b, cin));
    end
  end

  task automatic doReset();
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset sum", 32'(sum), 32'd0);
    checkOutput("reset cout", 32'(cout), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("in_ready after reset", 32'(in_ready), 32'd1);
  endtask

  // One transaction into an empty pipeline; reports latency, result and the following cycle's out_valid.
  task automatic applyStimulus(input vec_t v, output int latency, output logic [WIDTH-1:0] gotSum,
                               output logic gotCout, output logic validAfter);
    in_valid = 1'b1;
    a = v.a;
    b = v.b;
    cin = v.cin;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    cin = 1'($urandom);
    latency = -1;
    gotSum = '0;
    gotCout = 1'b0;
    for (int j = 1; j <= 10 && latency < 0; j++) begin
      @(negedge clk);
      if (out_valid) begin
        latency = j;
        gotSum = sum;
        gotCout = cout;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    validAfter = out_valid;
    @(posedge clk);
    #1;
  endtask

  // Random operand stream; optional fixed stall window or random out_ready.
  task automatic runStream(input int n, input int stallAt, input int stallLen, input bit randReady);
    int               sent;
    int               cyc;
    bit               accepted;
    logic [WIDTH-1:0] snapSum;
    logic             snapCout;
    sent = 0;
    cyc = 0;
    rxCount = 0;
    snapSum = '0;
    snapCout = 1'b0;
    in_valid = 1'b0;
    sbOn = 1'b1;
    while ((sent < n || expQ.size() != 0) && cyc < 2000) begin
      if (randReady) out_ready = 1'($urandom_range(0, 1));
      else out_ready = !(stallLen > 0 && cyc >= stallAt && cyc < stallAt + stallLen);
      if (!in_valid && sent < n) begin
        in_valid = 1'b1;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        cin = 1'($urandom);
      end
      @(negedge clk);
      if (!randReady && !out_ready) begin
        checkOutput("stall in_ready", 32'(in_ready), 32'd0);
        checkOutput("stall out_valid", 32'(out_valid), 32'd1);
        if (cyc == stallAt) begin
          snapSum = sum;
          snapCout = cout;
        end else begin
          checkOutput("stall sum stable", 32'(sum), 32'(snapSum));
          checkOutput("stall cout stable", 32'(cout), 32'(snapCout));
        end
      end
      accepted = in_valid && in_ready;
      if (accepted) sent++;
      @(posedge clk);
      #1;
      if (accepted) in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream drained", 32'(expQ.size()), 32'd0);
    checkOutput("stream result count", 32'(rxCount), 32'(n));
    if (!randReady) checkOutput("stream output span", 32'(lastRx - firstRx), 32'(n - 1 + stallLen));
    sbOn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int               lat;
    logic [WIDTH-1:0] gs;
    logic             gc;
    logic             va;
    int               validSeen;
    logic             pat [8];

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[4] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[8] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[9] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    doReset();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], lat, gs, gc, va);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(STAGES));
      checkOutput($sformatf("vec%0d sum", i), 32'(gs),
                  32'((SAT && vecs[i].cout) ? {WIDTH{1'b1}} : vecs[i].wrapSum));
      checkOutput($sformatf("vec%0d cout", i), 32'(gc), 32'(vecs[i].cout));
      checkOutput($sformatf("vec%0d valid after", i), 32'(va), 32'd0);
    end

    doReset();
    runStream(100, -1, 0, 1'b0);
    runStream(30, 10, 5, 1'b0);
    runStream(60, -1, 0, 1'b1);

    // Bubble pattern must reappear at the output exactly STAGES cycles later.
    doReset();
    sbOn = 1'b1;
    rxCount = 0;
    for (int j = 0; j < 8 + STAGES + 1; j++) begin
      in_valid = (j < 8) ? pat[j] : 1'b0;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      cin = 1'($urandom);
      @(negedge clk);
      checkOutput($sformatf("bubble out_valid c%0d", j), 32'(out_valid),
                  32'((j >= STAGES && j - STAGES < 8) ? pat[j - STAGES] : 1'b0));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("bubble result count", 32'(rxCount), 32'd5);
    sbOn = 1'b0;

    // Three transactions in flight, the oldest held at the output, then an asynchronous reset.
    doReset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      cin = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pre-reset out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid reset sum", 32'(sum), 32'd0);
    checkOutput("mid reset cout", 32'(cout), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    validSeen = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (out_valid) validSeen++;
      @(posedge clk);
      #1;
    end
    checkOutput("post reset results", 32'(validSeen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
